// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: opcodes, run-state encoding and FSM states.
package mem_access_pkg;

  localparam logic [4:0] OpLoad   = 5'b10000;
  localparam logic [4:0] OpLoadB  = 5'b10001;
  localparam logic [4:0] OpStore  = 5'b10010;
  localparam logic [4:0] OpStoreB = 5'b10011;

  localparam logic Exec = 1'b1;

  typedef enum logic {StIdle, StWait} mem_state_e;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OpLoad) || (op == OpLoadB) || (op == OpStore) || (op == OpStoreB);
  endfunction

  function automatic logic is_byte_op(input logic [4:0] op);
    return (op == OpLoadB) || (op == OpStoreB);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
);
  logic            d_req;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_dataout;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_datain;
  logic            d_ack;

  modport master (
    output d_req, d_addr, d_dataout, d_we, d_be,
    input  d_datain, d_ack
  );

  modport slave (
    input  d_req, d_addr, d_dataout, d_we, d_be,
    output d_datain, d_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store-data replication and load-byte extraction.
module mem_lane_align #(
  parameter int unsigned DW = 16
) (
  input  logic [$clog2(DW/8)-1:0] lane,
  input  logic                    byte_op,
  input  logic [DW-1:0]           st_data,
  input  logic [DW-1:0]           ld_data,
  output logic [DW/8-1:0]         be,
  output logic [DW-1:0]           wdata,
  output logic [DW-1:0]           ld_byte
);
  localparam int unsigned NB = DW / 8;

  always_comb begin
    be      = '1;
    wdata   = st_data;
    ld_byte = '0;
    if (byte_op) begin
      be       = '0;
      be[lane] = 1'b1;
      wdata    = {NB{st_data[7:0]}};
    end
    ld_byte[7:0] = ld_data[8*lane +: 8];
  end
endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream until ack or timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          state,
  input  logic [15:0]   mem_ir,
  input  logic [AW-1:0] reg_C,
  input  logic          dw,
  input  logic [DW-1:0] smdr1,
  mem_access_if.master  bus,
  output logic          stall,
  output logic [15:0]   wb_ir,
  output logic [DW-1:0] reg_C1,
  output logic          mem_err
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);

  mem_state_e fsm_q, fsm_d;

  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          we_q, we_d;
  logic [NB-1:0] be_q, be_d;
  logic [15:0]   wb_ir_q, wb_ir_d;
  logic [DW-1:0] reg_c1_q, reg_c1_d;
  logic          err_q, err_d;

  logic [4:0]    op;
  logic          mem_op, decide, timeout;
  logic [DW-1:0] reg_c_ext, lane_wdata, lane_ld_byte;
  logic [NB-1:0] lane_be;

  assign op        = mem_ir[15:11];
  assign mem_op    = is_mem_op(op);
  assign decide    = (fsm_q == StIdle) && (state == Exec);
  assign reg_c_ext = DW'(reg_C);
  // Fires on the edge that would bring the counter to MAX_WAIT.
  assign timeout   = (fsm_q == StWait) && !bus.d_ack && (wait_cnt_q == 8'(MAX_WAIT - 1));

  mem_lane_align #(
    .DW(DW)
  ) u_lane (
    .lane    (reg_C[LW-1:0]),
    .byte_op (is_byte_op(op)),
    .st_data (smdr1),
    .ld_data (bus.d_datain),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .ld_byte (lane_ld_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fsm_q <= StIdle;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (decide && mem_op) fsm_d = StWait;
      StWait:  if (bus.d_ack || timeout) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (fsm_q)
      StIdle:  stall = decide && mem_op;
      StWait:  stall = !bus.d_ack;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    we_d       = we_q;
    be_d       = be_q;
    wb_ir_d    = wb_ir_q;
    reg_c1_d   = reg_c1_q;
    err_d      = err_q;
    if (decide) begin
      if (mem_op) begin
        req_d      = 1'b1;
        addr_d     = reg_C;
        we_d       = dw;
        be_d       = lane_be;
        dout_d     = lane_wdata;
        wait_cnt_d = '0;
      end else begin
        wb_ir_d  = mem_ir;
        reg_c1_d = reg_c_ext;
      end
    end else if (fsm_q == StWait) begin
      if (bus.d_ack) begin
        req_d   = 1'b0;
        wb_ir_d = mem_ir;
        if (op == OpLoad)       reg_c1_d = bus.d_datain;
        else if (op == OpLoadB) reg_c1_d = lane_ld_byte;
        else                    reg_c1_d = reg_c_ext;
      end else if (timeout) begin
        err_d    = 1'b1;
        wb_ir_d  = '0;
        reg_c1_d = '0;
        req_d    = 1'b0;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wb_ir_q    <= '0;
      reg_c1_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wb_ir_q    <= wb_ir_d;
      reg_c1_q   <= reg_c1_d;
      err_q      <= err_d;
    end
  end

  assign bus.d_req     = req_q;
  assign bus.d_addr    = addr_q;
  assign bus.d_dataout = dout_q;
  assign bus.d_we      = we_q;
  assign bus.d_be      = be_q;
  assign wb_ir         = wb_ir_q;
  assign reg_C1        = reg_c1_q;
  assign mem_err       = err_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with DW=32, AW=16, MAX_WAIT=4.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clock;
  logic        reset;
  logic        state;
  logic [15:0] mem_ir;
  logic [15:0] reg_C;
  logic        dw;
  logic [31:0] smdr1;
  logic        stall;
  logic [15:0] wb_ir;
  logic [31:0] reg_C1;
  logic        mem_err;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_if #(.DW(32), .AW(16)) bus ();

  mem_access #(
    .DW       (32),
    .AW       (16),
    .MAX_WAIT (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .state   (state),
    .mem_ir  (mem_ir),
    .reg_C   (reg_C),
    .dw      (dw),
    .smdr1   (smdr1),
    .bus     (bus),
    .stall   (stall),
    .wb_ir   (wb_ir),
    .reg_C1  (reg_C1),
    .mem_err (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    state        = 1'b0;
    mem_ir       = '0;
    reg_C        = '0;
    dw           = 1'b0;
    smdr1        = '0;
    bus.d_ack    = 1'b0;
    bus.d_datain = '0;
    #2;
    check("rst_req",   bus.d_req, 1'b0);
    check("rst_be",    bus.d_be, 4'h0);
    check("rst_addr",  bus.d_addr, 16'h0);
    check("rst_wb_ir", wb_ir, 16'h0);
    check("rst_c1",    reg_C1, 32'h0);
    check("rst_err",   mem_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    tick();
    reset = 1'b1;

    // LOAD, ack in the second WAIT cycle
    state = Exec; mem_ir = {OpLoad, 11'h155}; reg_C = 16'h0040; dw = 1'b0;
    #1 check("ld_dec_stall", stall, 1'b1);
    tick();
    state = 1'b0;
    check("ld_req",   bus.d_req, 1'b1);
    check("ld_addr",  bus.d_addr, 16'h0040);
    check("ld_we",    bus.d_we, 1'b0);
    check("ld_be",    bus.d_be, 4'hF);
    check("ld_stall", stall, 1'b1);
    tick();
    check("ld_hold_req", bus.d_req, 1'b1);
    bus.d_ack = 1'b1; bus.d_datain = 32'h0000_BEEF;
    #1 check("ld_ack_stall", stall, 1'b0);
    tick();
    bus.d_ack = 1'b0;
    check("ld_done_req", bus.d_req, 1'b0);
    check("ld_c1",       reg_C1, 32'h0000_BEEF);
    check("ld_wb_ir",    wb_ir, {OpLoad, 11'h155});

    // STOREB to lane 2
    state = Exec; mem_ir = {OpStoreB, 11'h0}; reg_C = 16'h0102; smdr1 = 32'h0000_00A5; dw = 1'b1;
    tick();
    state = 1'b0;
    check("sb_be",   bus.d_be, 4'b0100);
    check("sb_data", bus.d_dataout, 32'hA5A5_A5A5);
    check("sb_we",   bus.d_we, 1'b1);
    check("sb_addr", bus.d_addr, 16'h0102);
    bus.d_ack = 1'b1;
    tick();
    bus.d_ack = 1'b0;
    check("sb_c1",    reg_C1, 32'h0000_0102);
    check("sb_wb_ir", wb_ir, {OpStoreB, 11'h0});

    // LOADB from lane 3
    state = Exec; mem_ir = {OpLoadB, 11'h3}; reg_C = 16'h0203; dw = 1'b0;
    tick();
    state = 1'b0;
    check("lb_be", bus.d_be, 4'b1000);
    tick();
    check("lb_hold_req", bus.d_req, 1'b1);
    bus.d_ack = 1'b1; bus.d_datain = 32'h12AB_CDEF;
    tick();
    bus.d_ack = 1'b0;
    check("lb_c1", reg_C1, 32'h0000_0012);

    // Full-word STORE
    state = Exec; mem_ir = {OpStore, 11'h0}; reg_C = 16'h0008; smdr1 = 32'hDEAD_BEEF; dw = 1'b1;
    tick();
    state = 1'b0;
    check("st_be",   bus.d_be, 4'hF);
    check("st_data", bus.d_dataout, 32'hDEAD_BEEF);
    bus.d_ack = 1'b1;
    tick();
    bus.d_ack = 1'b0;
    check("st_c1", reg_C1, 32'h0000_0008);

    // Non-memory op, then hold with stray ack while not exec
    state = Exec; mem_ir = {5'b00001, 11'h7}; reg_C = 16'h5A5A; dw = 1'b0;
    #1 check("nm_stall", stall, 1'b0);
    tick();
    state = 1'b0;
    check("nm_c1",    reg_C1, 32'h0000_5A5A);
    check("nm_wb_ir", wb_ir, {5'b00001, 11'h7});
    check("nm_req",   bus.d_req, 1'b0);
    mem_ir = {5'b00010, 11'h1}; reg_C = 16'hFFFF; bus.d_ack = 1'b1;
    tick();
    bus.d_ack = 1'b0;
    check("hold_c1",    reg_C1, 32'h0000_5A5A);
    check("hold_wb_ir", wb_ir, {5'b00001, 11'h7});
    check("hold_req",   bus.d_req, 1'b0);

    // Ack in the same cycle as the timeout wins
    state = Exec; mem_ir = {OpLoad, 11'h0}; reg_C = 16'h0010;
    tick();
    state = 1'b0;
    repeat (3) tick();
    bus.d_ack = 1'b1; bus.d_datain = 32'h0000_7777;
    tick();
    bus.d_ack = 1'b0;
    check("race_err", mem_err, 1'b0);
    check("race_c1",  reg_C1, 32'h0000_7777);
    check("race_req", bus.d_req, 1'b0);

    // Timeout after 4 WAIT cycles
    state = Exec; mem_ir = {OpLoad, 11'h2}; reg_C = 16'h0020;
    tick();
    state = 1'b0;
    repeat (3) tick();
    check("to_pre_req",   bus.d_req, 1'b1);
    check("to_pre_err",   mem_err, 1'b0);
    check("to_pre_stall", stall, 1'b1);
    tick();
    check("to_err",   mem_err, 1'b1);
    check("to_wb_ir", wb_ir, 16'h0);
    check("to_c1",    reg_C1, 32'h0);
    check("to_stall", stall, 1'b0);
    check("to_req",   bus.d_req, 1'b0);
    state = Exec; mem_ir = {5'b00001, 11'h0}; reg_C = 16'h0001;
    tick();
    state = 1'b0;
    check("to_sticky", mem_err, 1'b1);

    // Reset in the middle of WAIT
    state = Exec; mem_ir = {OpLoad, 11'h4}; reg_C = 16'h0030;
    tick();
    state = 1'b0;
    tick();
    check("rw_pre_req", bus.d_req, 1'b1);
    reset = 1'b0;
    #1;
    check("rw_req",   bus.d_req, 1'b0);
    check("rw_err",   mem_err, 1'b0);
    check("rw_wb_ir", wb_ir, 16'h0);
    mem_ir = {5'b00011, 11'h0}; reg_C = 16'h1234; state = Exec;
    @(negedge clock);
    reset = 1'b1;
    tick();
    state = 1'b0;
    check("rw_c1",    reg_C1, 32'h0000_1234);
    check("rw_after", wb_ir, {5'b00011, 11'h0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
